// File: rtl/run_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// run_ctrl_pkg
// Shared types and defaults for the program-launch controller.
//   run_state_t : controller state encoding (also exported for debug)
//   DEF_CNT_W   : default width of the executed-cycle counter
// ---------------------------------------------------------------------------
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } run_state_t;

    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/run_ctrl_if.sv
// ---------------------------------------------------------------------------
// run_ctrl_if
// Start/Ack launch handshake plus the execution-control strobes.
//
// Handshake: Start is a level from the launcher; only its rising edge is
// acted on. Ack is a registered done flag that stays high from the end of a
// run until the next rising edge of Start (it drops in the cycle INIT is
// entered). There is no backpressure; each launch is accepted exactly once.
//
//   Start    : launcher  -> run_ctrl  launch request level
//   Halt     : decoder   -> run_ctrl  current instruction is halt
//   Ack      : run_ctrl  -> launcher  run finished
//   PcInit   : run_ctrl  -> PC        force PC to 0 on next edge
//   RunEn    : run_ctrl  -> PC/RF     advance PC / commit writes
//   Busy     : run_ctrl  -> launcher  INIT or RUN
//   TimedOut : run_ctrl  -> launcher  last run ended by cycle budget
//   CycleCnt : run_ctrl  -> launcher  RUN cycles executed
//   State    : run_ctrl  -> debug     current controller state
// Modports: master = launcher/decoder side, slave = run_ctrl.
// ---------------------------------------------------------------------------
interface run_ctrl_if
    import run_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);

    logic             Start;
    logic             Halt;
    logic             Ack;
    logic             PcInit;
    logic             RunEn;
    logic             Busy;
    logic             TimedOut;
    logic [CNT_W-1:0] CycleCnt;
    run_state_t       State;

    modport master (
        output Start, Halt,
        input  Ack, PcInit, RunEn, Busy, TimedOut, CycleCnt, State
    );

    modport slave (
        input  Start, Halt,
        output Ack, PcInit, RunEn, Busy, TimedOut, CycleCnt, State
    );

endinterface

// File: rtl/run_ctrl_edge_det.sv
// ---------------------------------------------------------------------------
// edge_det
// One-flop rising-edge detector with synchronous active-high reset.
//   i_clk  : clock
//   i_rst  : synchronous reset, clears the history flop
//   i_d    : level input
//   o_rise : high while i_d is 1 and was 0 at the previous edge
// ---------------------------------------------------------------------------
module edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise
);

    logic r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/run_ctrl.sv
// ---------------------------------------------------------------------------
// run_ctrl
// Responder side of the Start/Ack program-launch handshake. A rising edge of
// Start holds the PC at 0 for one cycle (INIT), then enables execution (RUN)
// until the decoder flags halt or the cycle budget expires, then raises Ack
// (DONE) until the next launch.
//   Clk        : system clock
//   Reset      : synchronous active-high reset
//   bus        : run_ctrl_if.slave (Start/Halt in; Ack, PcInit, RunEn, Busy,
//                TimedOut, CycleCnt, State out)
// Parameters:
//   CNT_W      : width of the executed-cycle counter
//   MAX_CYCLES : RUN cycles allowed before forced abort (1 .. 2**CNT_W-1)
// ---------------------------------------------------------------------------
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int               CNT_W      = DEF_CNT_W,
    parameter logic [CNT_W-1:0] MAX_CYCLES = '1
) (
    input  logic     Clk,
    input  logic     Reset,
    run_ctrl_if.slave bus
);

    // Counter value seen during the last permitted RUN cycle.
    localparam logic [CNT_W-1:0] LAST_CNT = MAX_CYCLES - 1'b1;

    run_state_t       r_state;
    run_state_t       w_next;
    logic             w_start_rise;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic             r_timed_out;
    logic             w_ack;
    logic             w_pc_init;
    logic             w_run_en;
    logic             w_busy;

    edge_det u_start_edge (
        .i_clk  (Clk),
        .i_rst  (Reset),
        .i_d    (bus.Start),
        .o_rise (w_start_rise)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and outputs. RunEn is Mealy on Halt so the halt
    // instruction itself never commits.
    always_comb begin
        w_next    = r_state;
        w_ack     = 1'b0;
        w_pc_init = 1'b0;
        w_run_en  = 1'b0;
        w_busy    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_rise) begin
                    w_next = INIT;
                end
            end
            INIT: begin
                w_pc_init = 1'b1;
                w_busy    = 1'b1;
                w_next    = RUN;
            end
            RUN: begin
                w_busy   = 1'b1;
                w_run_en = ~bus.Halt;
                if (bus.Halt || (r_cycle_cnt == LAST_CNT)) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_ack = 1'b1;
                if (w_start_rise) begin
                    w_next = INIT;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Cycle counter and timeout flag. Both clear on the edge that enters
    // INIT so the new run reports from zero while PcInit is high.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cycle_cnt <= '0;
            r_timed_out <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_next == INIT) begin
                        r_cycle_cnt <= '0;
                        r_timed_out <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.Halt) begin
                        // Halt wins over budget expiry; halt cycle not counted.
                        r_timed_out <= 1'b0;
                    end else if (r_cycle_cnt == LAST_CNT) begin
                        r_cycle_cnt <= MAX_CYCLES;
                        r_timed_out <= 1'b1;
                    end else begin
                        r_cycle_cnt <= r_cycle_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.Ack      = w_ack;
    assign bus.PcInit   = w_pc_init;
    assign bus.RunEn    = w_run_en;
    assign bus.Busy     = w_busy;
    assign bus.TimedOut = r_timed_out;
    assign bus.CycleCnt = r_cycle_cnt;
    assign bus.State    = r_state;

endmodule
